pipelined_wordline_decoder: RTL and testbench
=============================================

// Module: pipelined_wordline_decoder
// PURPOSE
//  Parametrised, registered address-to-wordline decoder for memory_elements arrays (regfile, caches).
//  Splits ADDR_WIDTH address into CHUNK_WIDTH fields; predecodes each field to one-hot (registered stage 1).
//  Stage 2 ANDs the predecoded groups into 2**ADDR_WIDTH one-hot wordlines.
//  Drives each wordline for a timed pulse followed by a precharge/recover gap; upstream sees valid/ready.
// PARAMETERS
//  ADDR_WIDTH      8  address bits; ROWS = 2**ADDR_WIDTH wordlines
//  CHUNK_WIDTH     4  predecode field width; ADDR_WIDTH % CHUNK_WIDTH == 0 (elab error otherwise)
//  PULSE_CYCLES    1  cycles a wordline stays asserted (>=1)
//  RECOVER_CYCLES  1  all-zero cycles after each pulse (>=1)
// PORTS
//  clk             in   1           single clock, rising edge
//  reset_n         in   1           asynchronous, active-low reset
//  req_valid       in   1           request address valid
//  req_ready       out  1           decoder can accept request this cycle
//  req_address     in   ADDR_WIDTH  row address
//  wordline        out  ROWS        one-hot row select; all-zero when idle/recovering
//  wordline_active out  1           high exactly while wordline is driven
//  pulse_done      out  1           one-cycle strobe in last PULSE cycle
//  onehot_error    out  1           sticky decode-integrity flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, sync deassert upstream): s1_valid=0, state=IDLE, counter=0, wordline=0,
//   wordline_active=0, pulse_done=0, onehot_error=0; req_ready=1 first cycle after release.
//  Stage 1: on req_valid&&req_ready register NUM_CHUNKS=ADDR_WIDTH/CHUNK_WIDTH one-hot groups
//   (each 2**CHUNK_WIDTH bits) and set s1_valid. req_valid without req_ready: no effect.
//  req_ready = !s1_valid || s2_load (combinational; one-entry skid, full throughput).
//  s2_load = s1_valid && (state==IDLE || (state==RECOVER && counter==RECOVER_CYCLES-1)).
//  FSM: IDLE -s2_load-> DRIVE; DRIVE holds PULSE_CYCLES cycles -> RECOVER;
//   RECOVER holds RECOVER_CYCLES cycles -> DRIVE if s2_load else IDLE.
//  Counter reset to 0 on every state entry; width $clog2(max(PULSE,RECOVER)+1).
//  wordline registered: = AND of selected group bits in DRIVE, 0 otherwise; exactly one bit set in DRIVE.
//  Latency: accept at edge N -> wordline valid after edge N+2 (or later if FSM busy).
//  Throughput: one access per PULSE_CYCLES+RECOVER_CYCLES cycles; back-to-back never overlap wordlines.
//  Stage-1 entry held unchanged until loaded; address bits are don't-care when req_valid=0.
//  Address 0 -> wordline[0]; address ROWS-1 -> wordline[ROWS-1]; no wrap or out-of-range cases.
//  reset_n low mid-pulse: wordline drops to 0 immediately (async), pending stage-1 entry discarded.
// CONFIGURATION
//  Macro WORDLINE_ONEHOT_CHECK_EN:
//   defined: each cycle checks every stage-1 group is one-hot when s1_valid and wordline is one-hot
//    in DRIVE / zero otherwise; any violation sets onehot_error (sticky until reset).
//   undefined: checker logic absent, onehot_error tied 0; port list unchanged.
// STRUCTURE
//  Package memory_elements_pkg: wl_state_t enum {WL_IDLE, WL_DRIVE, WL_RECOVER};
//   function onehot_check(); localparam helpers for NUM_CHUNKS / group width.
//  Sub-module chunk_predecoder #(CHUNK_WIDTH): combinational field -> 2**CHUNK_WIDTH one-hot,
//   instantiated NUM_CHUNKS times via generate; registers stay in this module.
// TESTING
//  Reset: hold reset_n=0 3 cycles, drive req_valid=1 -> wordline=0, req_ready=0-independent, all outputs 0.
//  Single req addr=0xA5 (defaults) -> wordline[165]=1 only, 2 cycles after accept, 1 cycle, then 1 zero cycle.
//  Streaming addrs 0x00,0xFF,0x3C with req_valid held -> pulses every 2 cycles, never overlapping; order kept.
//  PULSE_CYCLES=3, RECOVER_CYCLES=2: addrs 1,2 back-to-back -> wordline[1] 3 cyc, 2 zero, wordline[2] 3 cyc; req_ready low while stage 1 full.
//  reset_n pulsed low mid-DRIVE with entry pending -> wordline 0 immediately; pending addr never driven.
//  WORDLINE_ONEHOT_CHECK_EN defined, force two stage-1 group bits -> onehot_error=1 next cycle, sticky; macro off -> stays 0.

Source files
------------

// File: rtl/memory_elements_pkg.sv
// Shared types and helpers for the memory-element decoders: FSM state encoding,
// predecode sizing helpers and a one-hot integrity test.
package memory_elements_pkg;

  typedef enum logic [1:0] {
    WL_IDLE    = 2'd0,
    WL_DRIVE   = 2'd1,
    WL_RECOVER = 2'd2
  } wl_state_t;

  // Widest vector onehot_check() accepts; callers zero-extend into it.
  localparam int ONEHOT_MAX_W = 1024;

  function automatic int num_chunks(input int addr_width, input int chunk_width);
    return addr_width / chunk_width;
  endfunction

  function automatic int group_width(input int chunk_width);
    return 1 << chunk_width;
  endfunction

  function automatic logic onehot_check(input logic [ONEHOT_MAX_W-1:0] vec);
    return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/chunk_predecoder.sv
// Combinational predecoder: one CHUNK_WIDTH address field to a one-hot group.
module chunk_predecoder #(
  parameter int CHUNK_WIDTH = 4
) (
  input  logic [CHUNK_WIDTH-1:0]      field,
  output logic [(1<<CHUNK_WIDTH)-1:0] onehot
);

  localparam int GW = 1 << CHUNK_WIDTH;
  localparam logic [GW-1:0] ONE = GW'(1);

  assign onehot = ONE << field;

endmodule

// File: rtl/pipelined_wordline_decoder.sv
// Two-stage registered address-to-wordline decoder with timed pulse/recover sequencing.
// Optional WORDLINE_ONEHOT_CHECK_EN adds a sticky decode-integrity checker on onehot_error.
module pipelined_wordline_decoder
  import memory_elements_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int CHUNK_WIDTH    = 4,
  parameter int PULSE_CYCLES   = 1,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_WIDTH-1:0]    req_address,
  output logic [(1<<ADDR_WIDTH)-1:0] wordline,
  output logic                     wordline_active,
  output logic                     pulse_done,
  output logic                     onehot_error
);

  localparam int ROWS       = 1 << ADDR_WIDTH;
  localparam int NUM_CHUNKS = num_chunks(ADDR_WIDTH, CHUNK_WIDTH);
  localparam int GW         = group_width(CHUNK_WIDTH);
  localparam int GROUPS_W   = NUM_CHUNKS * GW;
  localparam int CNT_MAX    = (PULSE_CYCLES > RECOVER_CYCLES) ? PULSE_CYCLES : RECOVER_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVER_CYCLES - 1);

  genvar gi, gc;

  generate
    if (ADDR_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_chunk
      $error("ADDR_WIDTH must be a multiple of CHUNK_WIDTH");
    end
    if (PULSE_CYCLES < 1 || RECOVER_CYCLES < 1) begin : g_bad_timing
      $error("PULSE_CYCLES and RECOVER_CYCLES must be at least 1");
    end
    if (ROWS > ONEHOT_MAX_W) begin : g_bad_rows
      $error("ADDR_WIDTH too large for onehot_check");
    end
  endgenerate

  logic [GROUPS_W-1:0] predec;
  logic [GROUPS_W-1:0] s1_groups_reg;
  logic                s1_valid_reg;
  logic [GROUPS_W-1:0] s2_groups_reg;
  wl_state_t           state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [ROWS-1:0]     row_decode;
  logic [ROWS-1:0]     wordline_reg;
  logic                wordline_active_reg;
  logic                pulse_done_reg;
  logic                s2_load;
  logic                accept;
  logic                recover_last;

  generate
    for (gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
      chunk_predecoder #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_predec (
        .field  (req_address[gi*CHUNK_WIDTH +: CHUNK_WIDTH]),
        .onehot (predec[gi*GW +: GW])
      );
    end
  endgenerate

  // Each row is the AND of the one bit it needs from every predecoded group.
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [NUM_CHUNKS-1:0] hits;
      for (gc = 0; gc < NUM_CHUNKS; gc++) begin : g_hit
        assign hits[gc] = s2_groups_reg[gc*GW + ((gi >> (gc*CHUNK_WIDTH)) % GW)];
      end
      assign row_decode[gi] = &hits;
    end
  endgenerate

  assign recover_last = (state_reg == WL_RECOVER) && (cnt_reg == RECOVER_LAST);
  assign s2_load      = s1_valid_reg && ((state_reg == WL_IDLE) || recover_last);
  assign req_ready    = !s1_valid_reg || s2_load;
  assign accept       = req_valid && req_ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      WL_IDLE: begin
        if (s2_load) begin
          state_next = WL_DRIVE;
          cnt_next   = '0;
        end
      end
      WL_DRIVE: begin
        if (cnt_reg == PULSE_LAST) begin
          state_next = WL_RECOVER;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WL_RECOVER: begin
        if (recover_last) begin
          state_next = s2_load ? WL_DRIVE : WL_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = WL_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg  <= 1'b0;
      s1_groups_reg <= '0;
      s2_groups_reg <= '0;
      state_reg     <= WL_IDLE;
      cnt_reg       <= '0;
    end else begin
      if (accept) begin
        s1_valid_reg  <= 1'b1;
        s1_groups_reg <= predec;
      end else if (s2_load) begin
        s1_valid_reg <= 1'b0;
      end
      if (s2_load) begin
        s2_groups_reg <= s1_groups_reg;
      end
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Output stage trails the FSM by one cycle so the AND tree sees settled groups.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wordline_reg        <= '0;
      wordline_active_reg <= 1'b0;
      pulse_done_reg      <= 1'b0;
    end else begin
      wordline_reg        <= (state_reg == WL_DRIVE) ? row_decode : '0;
      wordline_active_reg <= (state_reg == WL_DRIVE);
      pulse_done_reg      <= (state_reg == WL_DRIVE) && (cnt_reg == PULSE_LAST);
    end
  end

  assign wordline        = wordline_reg;
  assign wordline_active = wordline_active_reg;
  assign pulse_done      = pulse_done_reg;

`ifdef WORDLINE_ONEHOT_CHECK_EN
  logic group_bad;
  logic wordline_bad;
  logic onehot_error_reg;

  always_comb begin
    group_bad = 1'b0;
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      if (!onehot_check(ONEHOT_MAX_W'(s1_groups_reg[c*GW +: GW]))) begin
        group_bad = 1'b1;
      end
    end
    wordline_bad = wordline_active_reg ? !onehot_check(ONEHOT_MAX_W'(wordline_reg))
                                       : (wordline_reg != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      onehot_error_reg <= 1'b0;
    end else if ((s1_valid_reg && group_bad) || wordline_bad) begin
      onehot_error_reg <= 1'b1;
    end
  end

  assign onehot_error = onehot_error_reg;
`else
  assign onehot_error = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_wordline_decoder.sv
// Directed bench: default-timing instance u1 and PULSE=3/RECOVER=2 instance u2.
module tb_pipelined_wordline_decoder;

  logic         clk;
  logic         rst1_n, v1, rdy1, act1, pd1, err1;
  logic [7:0]   a1;
  logic [255:0] wl1;
  logic         rst2_n, v2, rdy2, act2, pd2, err2;
  logic [7:0]   a2;
  logic [255:0] wl2;
  logic [255:0] acc;
  int n_checks = 0;
  int n_pass   = 0;

  pipelined_wordline_decoder #(
    .ADDR_WIDTH(8), .CHUNK_WIDTH(4), .PULSE_CYCLES(1), .RECOVER_CYCLES(1)
  ) u1 (
    .clk(clk), .reset_n(rst1_n), .req_valid(v1), .req_ready(rdy1), .req_address(a1),
    .wordline(wl1), .wordline_active(act1), .pulse_done(pd1), .onehot_error(err1)
  );

  pipelined_wordline_decoder #(
    .ADDR_WIDTH(8), .CHUNK_WIDTH(4), .PULSE_CYCLES(3), .RECOVER_CYCLES(2)
  ) u2 (
    .clk(clk), .reset_n(rst2_n), .req_valid(v2), .req_ready(rdy2), .req_address(a2),
    .wordline(wl2), .wordline_active(act2), .pulse_done(pd2), .onehot_error(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [255:0] row(input int r);
    logic [255:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  initial begin
    rst1_n = 1'b0; v1 = 1'b1; a1 = 8'hA5;
    rst2_n = 1'b0; v2 = 1'b1; a2 = 8'h5A;

    // Reset held with requests offered
    repeat (3) tick();
    chk("rst_wl1", wl1, '0);
    chk("rst_act1", act1, 0);
    chk("rst_pd1", pd1, 0);
    chk("rst_err1", err1, 0);
    chk("rst_wl2", wl2, '0);
    v1 = 1'b0; v2 = 1'b0;
    rst1_n = 1'b1; rst2_n = 1'b1;
    tick();
    chk("rst_rdy1", rdy1, 1);
    chk("rst_rdy2", rdy2, 1);
    chk("rst_idle_wl1", wl1, '0);

    // Single request 0xA5
    v1 = 1'b1; a1 = 8'hA5;
    tick();
    v1 = 1'b0;
    chk("single_e1_wl", wl1, '0);
    tick();
    chk("single_e2_wl", wl1, '0);
    tick();
    chk("single_e3_wl", wl1, row(165));
    chk("single_e3_act", act1, 1);
    chk("single_e3_pd", pd1, 1);
    tick();
    chk("single_e4_wl", wl1, '0);
    chk("single_e4_act", act1, 0);
    chk("single_e4_pd", pd1, 0);

    // Streaming 0x00, 0xFF, 0x3C
    v1 = 1'b1; a1 = 8'h00;
    tick();
    chk("stream_e1_rdy", rdy1, 1);
    a1 = 8'hFF;
    tick();
    chk("stream_e2_wl", wl1, '0);
    chk("stream_e2_rdy", rdy1, 0);
    a1 = 8'h3C;
    tick();
    chk("stream_e3_wl", wl1, row(8'h00));
    chk("stream_e3_rdy", rdy1, 1);
    tick();
    chk("stream_e4_wl", wl1, '0);
    chk("stream_e4_rdy", rdy1, 0);
    v1 = 1'b0;
    tick();
    chk("stream_e5_wl", wl1, row(8'hFF));
    tick();
    chk("stream_e6_wl", wl1, '0);
    tick();
    chk("stream_e7_wl", wl1, row(8'h3C));
    tick();
    chk("stream_e8_wl", wl1, '0);
    chk("stream_err1", err1, 0);

    // PULSE=3 RECOVER=2: addresses 1 then 2
    v2 = 1'b1; a2 = 8'd1;
    tick();
    chk("p3_e1_rdy", rdy2, 1);
    a2 = 8'd2;
    tick();
    v2 = 1'b0;
    chk("p3_e2_rdy", rdy2, 0);
    chk("p3_e2_wl", wl2, '0);
    tick();
    chk("p3_e3_wl", wl2, row(1));
    chk("p3_e3_pd", pd2, 0);
    tick();
    chk("p3_e4_wl", wl2, row(1));
    tick();
    chk("p3_e5_wl", wl2, row(1));
    chk("p3_e5_pd", pd2, 1);
    chk("p3_e5_rdy", rdy2, 0);
    tick();
    chk("p3_e6_wl", wl2, '0);
    chk("p3_e6_rdy", rdy2, 1);
    tick();
    chk("p3_e7_wl", wl2, '0);
    tick();
    chk("p3_e8_wl", wl2, row(2));
    tick();
    chk("p3_e9_wl", wl2, row(2));
    tick();
    chk("p3_e10_wl", wl2, row(2));
    chk("p3_e10_pd", pd2, 1);
    tick();
    chk("p3_e11_wl", wl2, '0);
    chk("p3_e11_act", act2, 0);

    // Reset mid-DRIVE with 0x22 pending in stage 1
    v1 = 1'b1; a1 = 8'h11;
    tick();
    a1 = 8'h22;
    tick();
    v1 = 1'b0;
    tick();
    chk("midrst_pre_wl", wl1, row(8'h11));
    rst1_n = 1'b0;
    #1;
    chk("midrst_async_wl", wl1, '0);
    chk("midrst_async_act", act1, 0);
    tick();
    tick();
    rst1_n = 1'b1;
    tick();
    chk("midrst_rdy", rdy1, 1);
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      acc = acc | wl1;
      tick();
    end
    chk("midrst_pending_dropped", acc, '0);

`ifdef WORDLINE_ONEHOT_CHECK_EN
    chk("chk_err_pre", err1, 0);
    force u1.s1_groups_reg = 32'h0001_0003;
    force u1.s1_valid_reg  = 1'b1;
    tick();
    chk("chk_err_set", err1, 1);
    release u1.s1_groups_reg;
    release u1.s1_valid_reg;
    tick();
    tick();
    chk("chk_err_sticky", err1, 1);
    rst1_n = 1'b0;
    #1;
    chk("chk_err_cleared", err1, 0);
    tick();
    rst1_n = 1'b1;
    tick();
`else
    repeat (3) tick();
    chk("nochk_err1", err1, 0);
    chk("nochk_err2", err2, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
